// File: rtl/mcu_rst_seq.sv
// Reset and clock-enable sequencer: synchronised reset release, ordered per-domain
// release with programmable delays, dependency-ordered software reset, divided clock enable.
`timescale 1ns/1ps
module mcu_rst_seq #(
    parameter int NUM_DOM  = 4,
    parameter int DLY_W    = 8,
    parameter int SYNC_STG = 2,
    parameter int DIV_W    = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_DOM-1:0]       SW_RST_REQ,
    input  logic [NUM_DOM*DLY_W-1:0] DLY_CFG,
    input  logic [DIV_W-1:0]         CLKDIV_CFG,
    output logic [NUM_DOM-1:0]       DOM_RSTN,
    output logic                     CLK_EN,
    output logic                     SEQ_DONE,
    output logic [1:0]               SEQ_STATE
);

    localparam int IDX_W = $clog2(NUM_DOM + 1);

    typedef enum logic [1:0] {
        ST_HOLD = 2'b00,
        ST_SYNC = 2'b01,
        ST_SEQ  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t             state_r, state_s;
    logic [SYNC_STG-1:0] sync_r;
    logic [IDX_W-1:0]   idx_r, idx_s;
    logic [DLY_W-1:0]   cnt_r, cnt_s;
    logic [NUM_DOM-1:0] rstn_r, rstn_s;
    logic               done_r, done_s;
    logic [DIV_W-1:0]   div_r;
    logic               clk_en_r;
    logic [IDX_W-1:0]   req_k_s;
    logic               req_any_s;

    // Lowest set request index; NUM_DOM when no request is present.
    function automatic logic [IDX_W-1:0] low_idx(input logic [NUM_DOM-1:0] req);
        logic [IDX_W-1:0] k;
        k = IDX_W'(NUM_DOM);
        for (int i = NUM_DOM - 1; i >= 0; i--) begin
            if (req[i]) begin
                k = IDX_W'(i);
            end
        end
        return k;
    endfunction

    // Delay field of domain i; zero past the last domain.
    function automatic logic [DLY_W-1:0] dly_of(input logic [NUM_DOM*DLY_W-1:0] cfg,
                                                input logic [IDX_W-1:0] i);
        logic [DLY_W-1:0] d;
        d = {DLY_W{1'b0}};
        for (int n = 0; n < NUM_DOM; n++) begin
            if (i == IDX_W'(n)) begin
                d = cfg[n*DLY_W +: DLY_W];
            end
        end
        return d;
    endfunction

    // Mask keeping only domains below k released.
    function automatic logic [NUM_DOM-1:0] keep_below(input logic [IDX_W-1:0] k);
        logic [NUM_DOM-1:0] m;
        for (int n = 0; n < NUM_DOM; n++) begin
            m[n] = (IDX_W'(n) < k);
        end
        return m;
    endfunction

    assign req_k_s   = low_idx(SW_RST_REQ);
    assign req_any_s = |SW_RST_REQ;

    // Reset-release synchroniser chain.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_r <= {SYNC_STG{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STG-2:0], 1'b1};
        end
    end

    // Sequencer next-state, counter, index and domain reset logic.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        rstn_s  = rstn_r;
        done_s  = done_r;
        case (state_r)
            ST_HOLD: begin
                state_s = ST_SYNC;
            end
            ST_SYNC: begin
                if (sync_r[SYNC_STG-2]) begin
                    state_s = ST_SEQ;
                    idx_s   = {IDX_W{1'b0}};
                    cnt_s   = dly_of(DLY_CFG, {IDX_W{1'b0}});
                end else begin
                    state_s = ST_SYNC;
                end
            end
            ST_SEQ: begin
                // A request at the current index also restarts, so a held request keeps it in reset.
                if (req_any_s && (req_k_s <= idx_r)) begin
                    idx_s  = req_k_s;
                    cnt_s  = dly_of(DLY_CFG, req_k_s);
                    rstn_s = rstn_r & keep_below(req_k_s);
                end else if (idx_r == IDX_W'(NUM_DOM)) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end else if (cnt_r == {DLY_W{1'b0}}) begin
                    for (int n = 0; n < NUM_DOM; n++) begin
                        if (idx_r == IDX_W'(n)) begin
                            rstn_s[n] = 1'b1;
                        end else begin
                            rstn_s[n] = rstn_r[n];
                        end
                    end
                    idx_s = idx_r + IDX_W'(1);
                    cnt_s = dly_of(DLY_CFG, idx_r + IDX_W'(1));
                end else begin
                    cnt_s = cnt_r - DLY_W'(1);
                end
            end
            ST_DONE: begin
                if (req_any_s) begin
                    state_s = ST_SEQ;
                    done_s  = 1'b0;
                    idx_s   = req_k_s;
                    cnt_s   = dly_of(DLY_CFG, req_k_s);
                    rstn_s  = rstn_r & keep_below(req_k_s);
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_HOLD;
                rstn_s  = {NUM_DOM{1'b0}};
                done_s  = 1'b0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_HOLD;
            idx_r   <= {IDX_W{1'b0}};
            cnt_r   <= {DLY_W{1'b0}};
            rstn_r  <= {NUM_DOM{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            rstn_r  <= rstn_s;
            done_r  <= done_s;
        end
    end

    // Clock-enable divider; ">=" makes a lowered period wrap on the next edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_r    <= {DIV_W{1'b0}};
            clk_en_r <= 1'b0;
        end else if (state_r == ST_HOLD) begin
            div_r    <= {DIV_W{1'b0}};
            clk_en_r <= 1'b0;
        end else if (div_r >= CLKDIV_CFG) begin
            div_r    <= {DIV_W{1'b0}};
            clk_en_r <= 1'b1;
        end else begin
            div_r    <= div_r + DIV_W'(1);
            clk_en_r <= 1'b0;
        end
    end

    assign DOM_RSTN  = rstn_r;
    assign CLK_EN    = clk_en_r;
    assign SEQ_DONE  = done_r;
    assign SEQ_STATE = state_r;

endmodule

// File: tb/tb_mcu_rst_seq.sv
// Directed bench for mcu_rst_seq: power-up order, software resets, async reset pulse, clock enable.
`timescale 1ns/1ps
module tb_mcu_rst_seq;

    logic        CLK;
    logic        RST;
    logic [3:0]  SW_RST_REQ;
    logic [31:0] DLY_CFG;
    logic [3:0]  CLKDIV_CFG;
    logic [3:0]  DOM_RSTN;
    logic        CLK_EN;
    logic        SEQ_DONE;
    logic [1:0]  SEQ_STATE;

    int n_cmp = 0;
    int n_err = 0;
    logic found;

    mcu_rst_seq #(.NUM_DOM(4), .DLY_W(8), .SYNC_STG(2), .DIV_W(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SW_RST_REQ (SW_RST_REQ),
        .DLY_CFG    (DLY_CFG),
        .CLKDIV_CFG (CLKDIV_CFG),
        .DOM_RSTN   (DOM_RSTN),
        .CLK_EN     (CLK_EN),
        .SEQ_DONE   (SEQ_DONE),
        .SEQ_STATE  (SEQ_STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    initial begin
        RST        = 1'b1;
        SW_RST_REQ = 4'b0000;
        DLY_CFG    = {8'd3, 8'd0, 8'd2, 8'd1};
        CLKDIV_CFG = 4'd0;
        #3;
        check("rst_domrstn", DOM_RSTN, 32'h0);
        check("rst_done", SEQ_DONE, 32'h0);
        check("rst_clken", CLK_EN, 32'h0);
        check("rst_state", SEQ_STATE, 32'h0);

        // Power-up: RST falls just after edge 0.
        @(posedge CLK);
        #2;
        RST = 1'b0;
        tick(1);
        check("pu_e1_state", SEQ_STATE, 32'h1);
        check("pu_e1_clken", CLK_EN, 32'h0);
        tick(1);
        check("pu_e2_state", SEQ_STATE, 32'h2);
        check("pu_e2_clken", CLK_EN, 32'h1);
        check("pu_e2_dom", DOM_RSTN, 32'h0);
        tick(1);
        check("pu_e3_dom", DOM_RSTN, 32'h0);
        tick(1);
        check("pu_e4_dom", DOM_RSTN, 32'h1);
        tick(2);
        check("pu_e6_dom", DOM_RSTN, 32'h1);
        tick(1);
        check("pu_e7_dom", DOM_RSTN, 32'h3);
        tick(1);
        check("pu_e8_dom", DOM_RSTN, 32'h7);
        tick(3);
        check("pu_e11_dom", DOM_RSTN, 32'h7);
        tick(1);
        check("pu_e12_dom", DOM_RSTN, 32'hF);
        check("pu_e12_done", SEQ_DONE, 32'h0);
        tick(1);
        check("pu_e13_done", SEQ_DONE, 32'h1);
        check("pu_e13_state", SEQ_STATE, 32'h3);

        // One-cycle software reset of domains 1 and 2 in DONE.
        SW_RST_REQ = 4'b0110;
        tick(1);
        SW_RST_REQ = 4'b0000;
        check("sw_pulse_dom", DOM_RSTN, 32'h1);
        check("sw_pulse_state", SEQ_STATE, 32'h2);
        check("sw_pulse_done", SEQ_DONE, 32'h0);
        tick(2);
        check("sw_pulse_e2_dom", DOM_RSTN, 32'h1);
        tick(1);
        check("sw_pulse_e3_dom", DOM_RSTN, 32'h3);
        tick(1);
        check("sw_pulse_e4_dom", DOM_RSTN, 32'h7);
        tick(4);
        check("sw_pulse_e8_dom", DOM_RSTN, 32'hF);
        check("sw_pulse_e8_done", SEQ_DONE, 32'h0);
        tick(1);
        check("sw_pulse_e9_done", SEQ_DONE, 32'h1);

        // Domain 1 request held for 10 cycles.
        SW_RST_REQ = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("held_dom", DOM_RSTN, 32'h1);
        end
        SW_RST_REQ = 4'b0000;
        tick(2);
        check("held_rel_e2", DOM_RSTN, 32'h1);
        tick(1);
        check("held_rel_e3", DOM_RSTN, 32'h3);
        tick(6);
        check("held_done", SEQ_DONE, 32'h1);
        check("held_done_dom", DOM_RSTN, 32'hF);

        // Restart from domain 0; higher request ignored while idx=2.
        SW_RST_REQ = 4'b0001;
        tick(1);
        SW_RST_REQ = 4'b0000;
        check("r0_dom", DOM_RSTN, 32'h0);
        check("r0_state", SEQ_STATE, 32'h2);
        tick(5);
        check("r0_e6_dom", DOM_RSTN, 32'h3);
        SW_RST_REQ = 4'b1000;
        tick(1);
        check("ign_hi_dom", DOM_RSTN, 32'h7);
        SW_RST_REQ = 4'b0001;
        tick(1);
        SW_RST_REQ = 4'b0000;
        check("restart0_dom", DOM_RSTN, 32'h0);
        check("restart0_state", SEQ_STATE, 32'h2);
        tick(2);
        check("restart0_e2_dom", DOM_RSTN, 32'h1);

        // 1 ns RST pulse between edges mid-SEQ.
        #1;
        RST = 1'b1;
        #1;
        RST = 1'b0;
        check("pulse_dom", DOM_RSTN, 32'h0);
        check("pulse_state", SEQ_STATE, 32'h0);
        check("pulse_done", SEQ_DONE, 32'h0);
        check("pulse_clken", CLK_EN, 32'h0);
        tick(1);
        check("re_e1_state", SEQ_STATE, 32'h1);
        tick(1);
        check("re_e2_state", SEQ_STATE, 32'h2);
        tick(2);
        check("re_e4_dom", DOM_RSTN, 32'h1);
        tick(9);
        check("re_e13_done", SEQ_DONE, 32'h1);
        check("re_e13_dom", DOM_RSTN, 32'hF);

        // Clock-enable divider.
        CLKDIV_CFG = 4'd3;
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!found) begin
                tick(1);
                found = CLK_EN;
            end
        end
        check("div3_found", found, 32'h1);
        for (int r = 0; r < 2; r++) begin
            tick(1);
            check("div3_p1", CLK_EN, 32'h0);
            tick(1);
            check("div3_p2", CLK_EN, 32'h0);
            tick(1);
            check("div3_p3", CLK_EN, 32'h0);
            tick(1);
            check("div3_p4", CLK_EN, 32'h1);
        end
        CLKDIV_CFG = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("div0_en", CLK_EN, 32'h1);
        end
        RST = 1'b1;
        #1;
        check("final_rst_clken", CLK_EN, 32'h0);
        check("final_rst_state", SEQ_STATE, 32'h0);
        check("final_rst_dom", DOM_RSTN, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
